// File: rtl/spp_scheduler.sv
// spp_scheduler
//   Sequencing controller for the SPP stage. It runs CBS1 once. It then runs
//   three cascaded 5x5 max-pool passes per channel on a single shared pool
//   engine: m5 = pool(CBS1), m9 = pool(m5), m13 = pool(m9). Finally it runs
//   CBS2 over the concat. The block has no datapath; all handshakes are
//   one-cycle start pulses out and one-cycle done pulses in.
//
//   Optional feature: define SPP_SCHED_TIMEOUT_EN to bound every wait state
//   to TIMEOUT cycles. On expiry the controller returns to IDLE and raises a
//   sticky err flag. Without the macro, err is tied low and the wait states
//   wait indefinitely.
//
// Parameters
//   CH      channels produced by CBS1 (pool passes per stage), 1..2^CH_W
//   CH_W    width of the channel index
//   TIMEOUT maximum cycles spent in any wait state (timeout build only)
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   start                      begin a run (sampled only in IDLE)
//   abort                      synchronous cancel from any state
//   busy / done / err          status: not IDLE / end-of-run pulse / timeout
//   cbs1_start, cbs1_done      CBS1 handshake
//   pool_start, pool_done      pool engine handshake
//   pool_src_sel, pool_dst_sel pool buffers (0=CBS1,1=m5,2=m9,3=m13)
//   pool_ch                    channel being pooled
//   cbs2_start, cbs2_done      CBS2 handshake
module spp_scheduler #(
    parameter int CH      = 1,
    parameter int CH_W    = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            cbs1_start,
    input  logic            cbs1_done,
    output logic            pool_start,
    input  logic            pool_done,
    output logic [1:0]      pool_src_sel,
    output logic [1:0]      pool_dst_sel,
    output logic [CH_W-1:0] pool_ch,
    output logic            cbs2_start,
    input  logic            cbs2_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CBS1   = 3'd1;
    localparam logic [2:0] S_CBS1_W = 3'd2;
    localparam logic [2:0] S_POOL   = 3'd3;
    localparam logic [2:0] S_POOL_W = 3'd4;
    localparam logic [2:0] S_CBS2   = 3'd5;
    localparam logic [2:0] S_CBS2_W = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CH - 1);

    if (CH < 1 || CH > (1 << CH_W) || TIMEOUT < 1) begin : g_param_check
        $error("spp_scheduler: illegal CH / CH_W / TIMEOUT");
    end

    logic [2:0]      state, state_nxt;
    logic [1:0]      pass, pass_nxt;
    logic [CH_W-1:0] ch, ch_nxt;
    logic            wait_hit;
    logic            in_pool;

    // Done pulses count only in the wait state that expects them.
    always_comb begin
        wait_hit = 1'b0;
        case (state)
            S_CBS1_W: wait_hit = cbs1_done;
            S_POOL_W: wait_hit = pool_done;
            S_CBS2_W: wait_hit = cbs2_done;
            default:  wait_hit = 1'b0;
        endcase
    end

`ifdef SPP_SCHED_TIMEOUT_EN
    localparam int                TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] wait_cnt;
    logic            in_wait;
    logic            timed_out;
    logic            err_q;

    assign in_wait   = (state == S_CBS1_W) || (state == S_POOL_W) || (state == S_CBS2_W);
    // The wait counter holds TIMEOUT-1 during the TIMEOUT-th wait cycle.
    // A done pulse in that cycle is still accepted.
    assign timed_out = in_wait && !wait_hit && (wait_cnt == TO_LAST);

    // Wait states are always entered from a non-wait state, so clearing
    // outside them gives a zero count on every entry.
    always_ff @(posedge clk) begin
        if (reset || !in_wait) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (!abort) begin
            if (state == S_IDLE && start) begin
                err_q <= 1'b0;
            end else if (timed_out) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        pass_nxt  = pass;
        ch_nxt    = ch;
        case (state)
            S_IDLE:   if (start) state_nxt = S_CBS1;
            S_CBS1:   state_nxt = S_CBS1_W;
            S_CBS1_W: begin
                if (wait_hit) begin
                    state_nxt = S_POOL;
                    pass_nxt  = 2'd1;
                    ch_nxt    = '0;
                end
            end
            S_POOL:   state_nxt = S_POOL_W;
            S_POOL_W: begin
                if (wait_hit) begin
                    if (ch != CH_LAST) begin
                        ch_nxt    = ch + CH_W'(1);
                        state_nxt = S_POOL;
                    end else if (pass != 2'd3) begin
                        pass_nxt  = pass + 2'd1;
                        ch_nxt    = '0;
                        state_nxt = S_POOL;
                    end else begin
                        pass_nxt  = '0;
                        ch_nxt    = '0;
                        state_nxt = S_CBS2;
                    end
                end
            end
            S_CBS2:   state_nxt = S_CBS2_W;
            S_CBS2_W: if (wait_hit) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
`ifdef SPP_SCHED_TIMEOUT_EN
        if (timed_out) begin
            state_nxt = S_IDLE;
            pass_nxt  = '0;
            ch_nxt    = '0;
        end
`endif
        if (abort) begin
            state_nxt = S_IDLE;
            pass_nxt  = '0;
            ch_nxt    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            pass  <= '0;
            ch    <= '0;
        end else begin
            state <= state_nxt;
            pass  <= pass_nxt;
            ch    <= ch_nxt;
        end
    end

    assign in_pool      = (state == S_POOL) || (state == S_POOL_W);
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign cbs1_start   = (state == S_CBS1);
    assign pool_start   = (state == S_POOL);
    assign cbs2_start   = (state == S_CBS2);
    assign pool_src_sel = in_pool ? (pass - 2'd1) : 2'd0;
    assign pool_dst_sel = in_pool ? pass : 2'd0;
    assign pool_ch      = in_pool ? ch : '0;

endmodule

// File: tb/tb_spp_scheduler.sv
`timescale 1ns/1ps
module tb_spp_scheduler;

    localparam int CH_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, abort, cbs1_done, pool_done, cbs2_done;

    logic            a_busy, a_done, a_err, a_c1, a_p, a_c2;
    logic [1:0]      a_src, a_dst;
    logic [CH_W-1:0] a_ch;
    logic            b_busy, b_done, b_err, b_c1, b_p, b_c2;
    logic [1:0]      b_src, b_dst;
    logic [CH_W-1:0] b_ch;

    // Both instances share inputs; each test resets first and observes one.
    spp_scheduler #(.CH(1), .CH_W(CH_W), .TIMEOUT(16)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(a_busy), .done(a_done), .err(a_err),
        .cbs1_start(a_c1), .cbs1_done(cbs1_done),
        .pool_start(a_p), .pool_done(pool_done),
        .pool_src_sel(a_src), .pool_dst_sel(a_dst), .pool_ch(a_ch),
        .cbs2_start(a_c2), .cbs2_done(cbs2_done)
    );

    spp_scheduler #(.CH(3), .CH_W(CH_W), .TIMEOUT(16)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(b_busy), .done(b_done), .err(b_err),
        .cbs1_start(b_c1), .cbs1_done(cbs1_done),
        .pool_start(b_p), .pool_done(pool_done),
        .pool_src_sel(b_src), .pool_dst_sel(b_dst), .pool_ch(b_ch),
        .cbs2_start(b_c2), .cbs2_done(cbs2_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        start     = 1'b0;
        abort     = 1'b0;
        cbs1_done = 1'b0;
        pool_done = 1'b0;
        cbs2_done = 1'b0;
    endtask

    // {err, busy, done, cbs1_start, pool_start, cbs2_start, src, dst}
    function automatic logic [9:0] obs_a();
        return {a_err, a_busy, a_done, a_c1, a_p, a_c2, a_src, a_dst};
    endfunction

    function automatic logic [9:0] obs_b();
        return {b_err, b_busy, b_done, b_c1, b_p, b_c2, b_src, b_dst};
    endfunction

    logic [9:0] exp_a [1:12];

    // CH=1 run with zero-wait done pulses; start must already be driven.
    task automatic run_a(input bit spur, input bit chain);
        for (int c = 1; c <= 12; c++) begin
            step();
            clr_in();
            check($sformatf("a_cyc%0d%s", c, spur ? "_spur" : ""),
                  64'(obs_a()), 64'(exp_a[c]));
            cbs1_done = (c == 2);
            pool_done = (c == 4 || c == 6 || c == 8);
            cbs2_done = (c == 10);
            if (spur) begin
                if (c == 1) cbs1_done = 1'b1;
                if (c == 2) pool_done = 1'b1;
                if (c == 4) cbs2_done = 1'b1;
                if (c == 5) begin start = 1'b1; pool_done = 1'b1; end
                if (c == 7) start = 1'b1;
                if (c == 9) pool_done = 1'b1;
            end
            if (c == 11) start = 1'b1;
            if (c == 12) start = chain;
        end
    endtask

    // CH=3 run with a responder; pool_done comes after pd_delay wait cycles.
    task automatic run_b(input int pd_delay, output int done_cyc, output int ndone,
                         output int npool, output logic [63:0] ch_log,
                         output logic [63:0] dst_log);
        int pd;
        bit c1_seen, c2_seen;
        pd = -1; c1_seen = 1'b0; c2_seen = 1'b0;
        done_cyc = 0; ndone = 0; npool = 0; ch_log = '0; dst_log = '0;
        for (int c = 1; c <= 400; c++) begin
            step();
            clr_in();
            if (c1_seen) cbs1_done = 1'b1;
            if (c2_seen) cbs2_done = 1'b1;
            c1_seen = b_c1;
            c2_seen = b_c2;
            if (pd > 0) begin
                pd--;
                if (pd == 0) pool_done = 1'b1;
            end
            if (b_p) begin
                ch_log  = {ch_log[59:0], b_ch[3:0]};
                dst_log = {dst_log[59:0], 2'b00, b_dst};
                npool++;
                pd = pd_delay + 1;
            end
            if (b_done) begin
                ndone++;
                done_cyc = c;
            end
            if (!b_busy) break;
        end
        check("b_run_ends_idle", 64'(b_busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          done_cyc, ndone, npool;
        logic [63:0] ch_log, dst_log;

        exp_a[1]  = 10'b0_1_0_1_0_0_00_00;
        exp_a[2]  = 10'b0_1_0_0_0_0_00_00;
        exp_a[3]  = 10'b0_1_0_0_1_0_00_01;
        exp_a[4]  = 10'b0_1_0_0_0_0_00_01;
        exp_a[5]  = 10'b0_1_0_0_1_0_01_10;
        exp_a[6]  = 10'b0_1_0_0_0_0_01_10;
        exp_a[7]  = 10'b0_1_0_0_1_0_10_11;
        exp_a[8]  = 10'b0_1_0_0_0_0_10_11;
        exp_a[9]  = 10'b0_1_0_0_0_1_00_00;
        exp_a[10] = 10'b0_1_0_0_0_0_00_00;
        exp_a[11] = 10'b0_1_1_0_0_0_00_00;
        exp_a[12] = 10'b0_0_0_0_0_0_00_00;

        // Reset state
        clr_in();
        reset = 1'b1;
        repeat (3) step();
        check("reset_a", 64'({obs_a(), a_ch}), 64'(0));
        check("reset_b", 64'({obs_b(), b_ch}), 64'(0));
        reset = 1'b0;

        // CH=1 zero-wait run, chained into a run with spurious pulses
        start = 1'b1;
        run_a(1'b0, 1'b1);
        run_a(1'b1, 1'b0);
        step();
        check("a_idle_after_runs", 64'(a_busy), 64'(0));

        // CH=3, pool done delayed 4 cycles
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        start = 1'b1;
        run_b(4, done_cyc, ndone, npool, ch_log, dst_log);
        check("b_npool", 64'(npool), 64'(9));
        check("b_ch_seq", ch_log, 64'h012012012);
        check("b_dst_seq", dst_log, 64'h111222333);
        check("b_ndone", 64'(ndone), 64'(1));
        check("b_done_cycle", 64'(done_cyc), 64'(59));

        // Reset in CBS2_W with start held high
        reset = 1'b1;
        step();
        clr_in();
        reset = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            clr_in();
            cbs1_done = (c == 2);
            pool_done = (c == 4 || c == 6 || c == 8);
            cbs2_done = (c == 10);
        end
        check("a_in_cbs2_w", 64'(obs_a()), 64'(exp_a[10]));
        reset = 1'b1;
        start = 1'b1;
        step();
        check("a_reset_midrun", 64'({obs_a(), a_ch}), 64'(0));
        for (int i = 0; i < 2; i++) begin
            step();
            check("a_reset_start_held", 64'(a_busy), 64'(0));
        end
        reset = 1'b0;
        step();
        check("a_start_after_reset", 64'(obs_a()), 64'(exp_a[1]));

        // Abort in POOL_W pass 2 ch 0, with coincident pool_done and start
        clr_in();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            clr_in();
            cbs1_done = (c == 2);
            pool_done = (c == 4 || c == 6 || c == 8);
            if (c == 9) check("b_pass2_ch0", 64'({b_p, b_src, b_dst, b_ch}), 64'({1'b1, 2'd1, 2'd2, 8'd0}));
            if (c == 10) begin
                abort     = 1'b1;
                pool_done = 1'b1;
                start     = 1'b1;
            end
        end
        step();
        clr_in();
        check("b_after_abort", 64'({obs_b(), b_ch}), 64'(0));
        step();
        check("b_stays_idle", 64'(b_busy), 64'(0));
        start = 1'b1;
        run_b(0, done_cyc, ndone, npool, ch_log, dst_log);
        check("b_restart_npool", 64'(npool), 64'(9));
        check("b_restart_ndone", 64'(ndone), 64'(1));
        check("b_restart_done_cycle", 64'(done_cyc), 64'(23));

`ifdef SPP_SCHED_TIMEOUT_EN
        // cbs1_done withheld: 16 wait cycles (2..17), IDLE with err in 18
        reset = 1'b1;
        repeat (2) step();
        clr_in();
        reset = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            step();
            clr_in();
        end
        check("a_to_last_wait", 64'({a_err, a_busy}), 64'(2'b01));
        step();
        check("a_to_expired", 64'({a_err, a_busy}), 64'(2'b10));
        repeat (3) step();
        check("a_err_sticky", 64'(a_err), 64'(1));
        start = 1'b1;
        step();
        clr_in();
        check("a_err_cleared", 64'({a_err, a_c1}), 64'(2'b01));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
